// File: rtl/prelude_loader_if.sv
// Host/loader bus bundle: byte command stream in, byte response stream out,
// CPU run/reset controls and the program-memory port.
// The loader connects through the slave modport; the host/memory side uses master.
//   rx_*       : host -> loader command/data bytes (valid/ready)
//   tx_*       : loader -> host response bytes (valid/ready, held until accepted)
//   cpu_*      : CPU clock enable and one-cycle synchronous reset pulse
//   pmem_*     : program memory write strobe/address/data; pmem_rdata is
//                combinational read data, present only with PRELUDE_LOADER_READBACK_EN
interface prelude_loader_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       cpu_run_en;
    logic       cpu_rst;
    logic       pmem_we;
    logic [7:0] pmem_addr;
    logic [7:0] pmem_wdata;
`ifdef PRELUDE_LOADER_READBACK_EN
    logic [7:0] pmem_rdata;
`endif

    // Host / memory side.
    modport master (
        output rx_data, rx_valid, tx_ready,
`ifdef PRELUDE_LOADER_READBACK_EN
        output pmem_rdata,
`endif
        input  rx_ready, tx_data, tx_valid, cpu_run_en, cpu_rst,
        input  pmem_we, pmem_addr, pmem_wdata
    );

    // Loader side.
    modport slave (
        input  rx_data, rx_valid, tx_ready,
`ifdef PRELUDE_LOADER_READBACK_EN
        input  pmem_rdata,
`endif
        output rx_ready, tx_data, tx_valid, cpu_run_en, cpu_rst,
        output pmem_we, pmem_addr, pmem_wdata
    );
endinterface

// File: rtl/prelude_loader.sv
// Purpose: byte-command boot loader; runs/halts/steps/resets a CPU and loads program memory.
// Latency: write strobe same cycle as the data byte handshake; response byte valid the cycle after the command completes.
// Backpressure: rx stalls (rx_ready=0) while a response or readback byte is pending; tx held stable until tx_ready.
//
// Ports:
//   clk    - system clock, all state on the rising edge
//   reset  - asynchronous active-high reset
//   bus    - prelude_loader_if.slave (rx/tx byte streams, CPU controls, program memory port)
//
// Commands (first byte in CMD state), every one answered with 0x06 or 0x15 (unknown):
//   'R' 0x52 run, 'H' 0x48 halt, 'S' 0x53 single step, 'X' 0x58 CPU reset,
//   'L' 0x4C load: addr, count (0 = 256), then count data bytes; CPU reset pulse at end.
//   'D' 0x44 dump: addr, count, then count bytes of memory read back on tx.
//       Present only when PRELUDE_LOADER_READBACK_EN is defined; otherwise 0x44 is unknown.
module prelude_loader (
    input  logic            clk,
    input  logic            reset,
    prelude_loader_if.slave bus
);

    localparam logic [7:0] CMD_RUN   = 8'h52;
    localparam logic [7:0] CMD_HALT  = 8'h48;
    localparam logic [7:0] CMD_STEP  = 8'h53;
    localparam logic [7:0] CMD_RESET = 8'h58;
    localparam logic [7:0] CMD_LOAD  = 8'h4C;
`ifdef PRELUDE_LOADER_READBACK_EN
    localparam logic [7:0] CMD_DUMP  = 8'h44;
`endif
    localparam logic [7:0] RSP_ACK   = 8'h06;
    localparam logic [7:0] RSP_NAK   = 8'h15;

    typedef enum logic [2:0] {
        ST_CMD,
        ST_LD_ADDR,
        ST_LD_CNT,
        ST_LD_DATA,
`ifdef PRELUDE_LOADER_READBACK_EN
        ST_RD_DATA,
`endif
        ST_ACK
    } state_t;

    state_t     state;
    logic       alive;      // low during reset, high from the first edge after release
    logic       run;        // persistent run flag ('R'/'H')
    logic       step;       // single-cycle enable after 'S'
    logic       cpu_rst_q;
    logic       tx_valid_q;
    logic [7:0] tx_q;
    logic [7:0] addr;
    logic [7:0] cnt;        // bytes remaining minus one, so a count byte of 0 gives 256
`ifdef PRELUDE_LOADER_READBACK_EN
    logic       rd_mode;    // address/count phase belongs to a dump rather than a load
`endif

    logic rx_fire;
    logic tx_fire;

    assign rx_fire = bus.rx_valid && bus.rx_ready;
    assign tx_fire = bus.tx_valid && bus.tx_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_CMD;
            alive      <= 1'b0;
            run        <= 1'b0;
            step       <= 1'b0;
            cpu_rst_q  <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_q       <= 8'h00;
            addr       <= 8'h00;
            cnt        <= 8'h00;
`ifdef PRELUDE_LOADER_READBACK_EN
            rd_mode    <= 1'b0;
`endif
        end else begin
            alive     <= 1'b1;
            // Pulses default low and are raised for exactly one cycle below.
            step      <= 1'b0;
            cpu_rst_q <= 1'b0;

            case (state)
                ST_CMD: begin
                    if (rx_fire) begin
                        case (bus.rx_data)
                            CMD_RUN: begin
                                run        <= 1'b1;
                                tx_q       <= RSP_ACK;
                                tx_valid_q <= 1'b1;
                                state      <= ST_ACK;
                            end
                            CMD_HALT: begin
                                run        <= 1'b0;
                                tx_q       <= RSP_ACK;
                                tx_valid_q <= 1'b1;
                                state      <= ST_ACK;
                            end
                            CMD_STEP: begin
                                run        <= 1'b0;
                                step       <= 1'b1;
                                tx_q       <= RSP_ACK;
                                tx_valid_q <= 1'b1;
                                state      <= ST_ACK;
                            end
                            CMD_RESET: begin
                                run        <= 1'b0;
                                cpu_rst_q  <= 1'b1;
                                tx_q       <= RSP_ACK;
                                tx_valid_q <= 1'b1;
                                state      <= ST_ACK;
                            end
                            CMD_LOAD: begin
                                // CPU stops on the very next cycle so it never
                                // executes from a half-written image.
                                run     <= 1'b0;
`ifdef PRELUDE_LOADER_READBACK_EN
                                rd_mode <= 1'b0;
`endif
                                state   <= ST_LD_ADDR;
                            end
`ifdef PRELUDE_LOADER_READBACK_EN
                            CMD_DUMP: begin
                                run     <= 1'b0;
                                rd_mode <= 1'b1;
                                state   <= ST_LD_ADDR;
                            end
`endif
                            default: begin
                                tx_q       <= RSP_NAK;
                                tx_valid_q <= 1'b1;
                                state      <= ST_ACK;
                            end
                        endcase
                    end
                end

                ST_LD_ADDR: begin
                    if (rx_fire) begin
                        addr  <= bus.rx_data;
                        state <= ST_LD_CNT;
                    end
                end

                ST_LD_CNT: begin
                    if (rx_fire) begin
                        cnt <= bus.rx_data - 8'd1;
`ifdef PRELUDE_LOADER_READBACK_EN
                        if (rd_mode) begin
                            // First readback byte is already on pmem_rdata.
                            tx_valid_q <= 1'b1;
                            state      <= ST_RD_DATA;
                        end else begin
                            state <= ST_LD_DATA;
                        end
`else
                        state <= ST_LD_DATA;
`endif
                    end
                end

                ST_LD_DATA: begin
                    if (rx_fire) begin
                        addr <= addr + 8'd1;
                        if (cnt == 8'h00) begin
                            cpu_rst_q  <= 1'b1;
                            tx_q       <= RSP_ACK;
                            tx_valid_q <= 1'b1;
                            state      <= ST_ACK;
                        end else begin
                            cnt <= cnt - 8'd1;
                        end
                    end
                end

`ifdef PRELUDE_LOADER_READBACK_EN
                ST_RD_DATA: begin
                    if (tx_fire) begin
                        addr <= addr + 8'd1;
                        if (cnt == 8'h00) begin
                            // tx_valid stays high; the ACK byte follows directly.
                            tx_q  <= RSP_ACK;
                            state <= ST_ACK;
                        end else begin
                            cnt <= cnt - 8'd1;
                        end
                    end
                end
`endif

                ST_ACK: begin
                    if (tx_fire) begin
                        tx_valid_q <= 1'b0;
                        state      <= ST_CMD;
                    end
                end

                default: state <= ST_CMD;
            endcase
        end
    end

    assign bus.rx_ready = alive && ((state == ST_CMD) || (state == ST_LD_ADDR) ||
                                    (state == ST_LD_CNT) || (state == ST_LD_DATA));
    assign bus.tx_valid = tx_valid_q;

    // Readback bytes come straight from the combinational memory read so the
    // address register alone selects the byte; it only moves on a tx handshake,
    // which keeps tx_data stable while the host stalls.
`ifdef PRELUDE_LOADER_READBACK_EN
    assign bus.tx_data = (state == ST_RD_DATA) ? bus.pmem_rdata : tx_q;
`else
    assign bus.tx_data = tx_q;
`endif

    assign bus.cpu_run_en = run || step;
    assign bus.cpu_rst    = cpu_rst_q;

    // Writes coincide with the data byte handshake.
    assign bus.pmem_we    = (state == ST_LD_DATA) && rx_fire;
    assign bus.pmem_addr  = addr;
    assign bus.pmem_wdata = (state == ST_LD_DATA) ? bus.rx_data : 8'h00;

endmodule

// File: tb/tb_prelude_loader.sv
`timescale 1ns/1ps
module tb_prelude_loader;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    prelude_loader_if bus();

    prelude_loader dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Program memory as written by the DUT, and the image the model expects.
    bit [7:0] pmem    [256];
    bit [7:0] exp_mem [256];

`ifdef PRELUDE_LOADER_READBACK_EN
    assign bus.pmem_rdata = pmem[bus.pmem_addr];
`endif

    logic [15:0] wr_q [$];
    int wr_cnt  = 0;
    int rst_cnt = 0;
    int run_cyc = 0;
    int n_chk   = 0;
    int n_fail  = 0;
    bit exp_run = 1'b0;

    // Observe at the falling edge: values here are what the next rising edge uses.
    always @(negedge clk) begin
        if (bus.pmem_we) begin
            pmem[bus.pmem_addr] = bus.pmem_wdata;
            wr_q.push_back({bus.pmem_addr, bus.pmem_wdata});
            wr_cnt++;
        end
        if (bus.cpu_rst)    rst_cnt++;
        if (bus.cpu_run_en) run_cyc++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        while (!bus.rx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.rx_ready) check("rx_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
    endtask

    task automatic recv_byte(input string tag, input logic [7:0] exp, input int hold);
        int n = 0;
        while (!bus.tx_valid && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, {31'd0, bus.tx_valid}, 32'd1);
        check(tag, {24'd0, bus.tx_data}, {24'd0, exp});
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, "_hold"}, {23'd0, bus.tx_valid, bus.tx_data}, {23'd0, 1'b1, exp});
        end
        bus.tx_ready = 1'b1;
        tick();
        bus.tx_ready = 1'b0;
    endtask

    // Single-byte commands: model decides response, run flag, step and reset pulses.
    task automatic do_simple(input logic [7:0] c);
        int  r0, s0;
        bit  known = 1'b1;
        bit  is_step = 1'b0;
        bit  is_xrst = 1'b0;
        case (c)
            8'h52: exp_run = 1'b1;
            8'h48: exp_run = 1'b0;
            8'h53: begin exp_run = 1'b0; is_step = 1'b1; end
            8'h58: begin exp_run = 1'b0; is_xrst = 1'b1; end
            default: known = 1'b0;
        endcase
        r0 = rst_cnt;
        send_byte(c);
        s0 = run_cyc;
        recv_byte("ack", known ? 8'h06 : 8'h15, $urandom_range(0, 2));
        tick();
        tick();
        check("run_en", {31'd0, bus.cpu_run_en}, {31'd0, exp_run});
        if (is_step) check("step_cycles", run_cyc - s0, 32'd1);
        check("cpu_rst_pulses", rst_cnt - r0, is_xrst ? 32'd1 : 32'd0);
    endtask

    task automatic do_load(input logic [7:0] a, input logic [7:0] d [$]);
        int          n, r0;
        logic [7:0]  ea;
        logic [15:0] w;
        n = d.size();
        wr_q.delete();
        r0 = rst_cnt;
        send_byte(8'h4C);
        check("load_run_off", {31'd0, bus.cpu_run_en}, 32'd0);
        exp_run = 1'b0;
        send_byte(a);
        send_byte(8'(n));
        for (int i = 0; i < n; i++) begin
            send_byte(d[i]);
            if (i < n - 1) check("load_no_ack", {31'd0, bus.tx_valid}, 32'd0);
            ea = a + 8'(i);
            exp_mem[ea] = d[i];
        end
        check("load_writes", wr_q.size(), n);
        for (int i = 0; i < n; i++) begin
            if (wr_q.size() > 0) begin
                w  = wr_q.pop_front();
                ea = a + 8'(i);
                check("load_wr", {16'd0, w}, {16'd0, ea, d[i]});
            end
        end
        recv_byte("load_ack", 8'h06, 0);
        check("load_rst", rst_cnt - r0, 32'd1);
        check("load_run", {31'd0, bus.cpu_run_en}, 32'd0);
    endtask

`ifdef PRELUDE_LOADER_READBACK_EN
    task automatic do_dump(input logic [7:0] a, input int n, input int hold);
        logic [7:0] ea;
        send_byte(8'h44);
        check("dump_run_off", {31'd0, bus.cpu_run_en}, 32'd0);
        exp_run = 1'b0;
        send_byte(a);
        send_byte(8'(n));
        for (int i = 0; i < n; i++) begin
            ea = a + 8'(i);
            check("dump_rx_rdy", {31'd0, bus.rx_ready}, 32'd0);
            recv_byte("dump_dat", exp_mem[ea], hold);
        end
        recv_byte("dump_ack", 8'h06, 0);
    endtask
`endif

    function automatic logic [7:0] junk_byte();
        logic [7:0] b;
        b = 8'($urandom);
        while (b == 8'h52 || b == 8'h48 || b == 8'h53 || b == 8'h58 ||
               b == 8'h4C || b == 8'h44)
            b = 8'($urandom);
        return b;
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] q [$];
        int w0, bad;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b0;
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rx_ready",   {31'd0, bus.rx_ready},   32'd0);
        check("rst_tx_valid",   {31'd0, bus.tx_valid},   32'd0);
        check("rst_tx_data",    {24'd0, bus.tx_data},    32'd0);
        check("rst_run_en",     {31'd0, bus.cpu_run_en}, 32'd0);
        check("rst_cpu_rst",    {31'd0, bus.cpu_rst},    32'd0);
        check("rst_pmem_we",    {31'd0, bus.pmem_we},    32'd0);
        check("rst_pmem_addr",  {24'd0, bus.pmem_addr},  32'd0);
        check("rst_pmem_wdata", {24'd0, bus.pmem_wdata}, 32'd0);
        reset = 1'b0;
        #1;
        check("rel_rx_ready_pre_edge", {31'd0, bus.rx_ready}, 32'd0);
        tick();
        check("rel_rx_ready", {31'd0, bus.rx_ready}, 32'd1);

        // Run / halt, then a single step from halt.
        do_simple(8'h52);
        do_simple(8'h48);
        do_simple(8'h53);

        // Load while running, wrapping through 0xFF.
        do_simple(8'h52);
        q = '{8'hAA, 8'hBB, 8'hCC};
        do_load(8'hFE, q);

`ifdef PRELUDE_LOADER_READBACK_EN
        do_dump(8'hFF, 2, 5);
`else
        do_simple(8'h44);
`endif
        do_simple(8'h58);

        // Count byte 0 means 256 bytes, wrapping the full address space.
        q.delete();
        for (int i = 0; i < 256; i++) q.push_back(8'($urandom));
        do_load(8'h10, q);

        // Randomized command mix.
        repeat (60) begin
            case ($urandom_range(0, 6))
                0: do_simple(8'h52);
                1: do_simple(8'h48);
                2: do_simple(8'h53);
                3: do_simple(8'h58);
                4: begin
                    q.delete();
                    for (int i = 0; i < int'($urandom_range(1, 6)); i++) q.push_back(8'($urandom));
                    if (q.size() == 0) q.push_back(8'h5A);
                    do_load(8'($urandom), q);
                end
                5: do_simple(junk_byte());
                default: begin
`ifdef PRELUDE_LOADER_READBACK_EN
                    do_dump(8'($urandom), $urandom_range(1, 4), $urandom_range(0, 2));
`else
                    do_simple(8'h44);
`endif
                end
            endcase
        end

        // Reset in the middle of a load: one write, no ACK, then normal service.
        w0 = wr_cnt;
        send_byte(8'h4C);
        send_byte(8'h20);
        send_byte(8'h04);
        send_byte(8'h01);
        exp_mem[8'h20] = 8'h01;
        exp_run = 1'b0;
        repeat (3) begin
            tick();
            check("midload_no_ack", {31'd0, bus.tx_valid}, 32'd0);
        end
        reset = 1'b1;
        #1;
        check("midload_rst_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("midload_writes", wr_cnt - w0, 32'd1);
        check("midload_rx_ready", {31'd0, bus.rx_ready}, 32'd1);
        do_simple(8'h48);

        bad = 0;
        for (int i = 0; i < 256; i++) if (pmem[i] != exp_mem[i]) bad++;
        check("mem_image", bad, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
